// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB writeback mux, 32x32 register file, retire counter and commit trace.
// Optional RF_WB_BYPASS_EN: write-first bypass of the committing value onto the read ports.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic            wb_rf_we,
  input  logic [1:0]      wb_rf_wsel,
  input  logic [XLEN-1:0] wb_C,
  input  logic [XLEN-1:0] wb_rdo,
  input  logic [XLEN-1:0] wb_pc4,
  input  logic [XLEN-1:0] wb_ext,
  input  logic [AW-1:0]   wb_wR,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [AW-1:0]   rR1,
  input  logic [AW-1:0]   rR2,
  output logic [XLEN-1:0] rD1,
  output logic [XLEN-1:0] rD2,
  output logic [XLEN-1:0] wb_wD,
  output logic [31:0]     retire_cnt,
  output logic            dbg_wb_have_inst,
  output logic [XLEN-1:0] dbg_wb_pc,
  output logic            dbg_wb_ena,
  output logic [AW-1:0]   dbg_wb_reg,
  output logic [XLEN-1:0] dbg_wb_value
);
  logic [XLEN-1:0] regs [NREG];
  logic commit;
  always_comb begin
    wb_wD = wb_rf_wsel[1] ? (wb_rf_wsel[0] ? wb_ext : wb_pc4)
                          : (wb_rf_wsel[0] ? wb_rdo : wb_C);
    commit = wb_valid & wb_rf_we & (wb_wR != '0);
  end
`ifdef RF_WB_BYPASS_EN
  assign rD1 = (rR1 == '0) ? '0 : (commit && rR1 == wb_wR) ? wb_wD : regs[rR1];
  assign rD2 = (rR2 == '0) ? '0 : (commit && rR2 == wb_wR) ? wb_wD : regs[rR2];
`else
  assign rD1 = (rR1 == '0) ? '0 : regs[rR1];
  assign rD2 = (rR2 == '0) ? '0 : regs[rR2];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wb_wR] <= wb_wD;
    end
  end
  // Counter is written every cycle so a held value simply re-latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt       <= '0;
      dbg_wb_have_inst <= 1'b0;
      dbg_wb_pc        <= '0;
      dbg_wb_ena       <= 1'b0;
      dbg_wb_reg       <= '0;
      dbg_wb_value     <= '0;
    end else begin
      retire_cnt       <= retire_cnt + {31'b0, wb_valid};
      dbg_wb_have_inst <= wb_valid;
      dbg_wb_pc        <= wb_pc;
      dbg_wb_ena       <= commit;
      dbg_wb_reg       <= wb_wR;
      dbg_wb_value     <= wb_wD;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_rf_we;
  logic [1:0]  wb_rf_wsel;
  logic [31:0] wb_C, wb_rdo, wb_pc4, wb_ext, wb_pc;
  logic [4:0]  wb_wR, rR1, rR2;
  logic [31:0] rD1, rD2, wb_wD, retire_cnt, dbg_wb_pc, dbg_wb_value;
  logic        dbg_wb_have_inst, dbg_wb_ena;
  logic [4:0]  dbg_wb_reg;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cnt;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_rf_we(wb_rf_we),
    .wb_rf_wsel(wb_rf_wsel), .wb_C(wb_C), .wb_rdo(wb_rdo), .wb_pc4(wb_pc4),
    .wb_ext(wb_ext), .wb_wR(wb_wR), .wb_pc(wb_pc), .rR1(rR1), .rR2(rR2),
    .rD1(rD1), .rD2(rD2), .wb_wD(wb_wD), .retire_cnt(retire_cnt),
    .dbg_wb_have_inst(dbg_wb_have_inst), .dbg_wb_pc(dbg_wb_pc),
    .dbg_wb_ena(dbg_wb_ena), .dbg_wb_reg(dbg_wb_reg), .dbg_wb_value(dbg_wb_value)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                       input logic [4:0] wr, input logic [31:0] c);
    wb_valid = v; wb_rf_we = we; wb_rf_wsel = sel; wb_wR = wr; wb_C = c;
  endtask

  task automatic idle;
    wb_valid = 1'b0; wb_rf_we = 1'b0;
  endtask

  task automatic test_reset;
    drive(1, 1, 2'b00, 5'd1, 32'h1111_0001); tick;
    drive(1, 1, 2'b00, 5'd2, 32'h2222_0002); tick;
    drive(1, 1, 2'b00, 5'd31, 32'h3333_001F); tick;
    idle; rst = 1'b1; tick; tick;
    for (int a = 0; a < 32; a++) begin
      rR1 = 5'(a); rR2 = 5'(31 - a); #1;
      checks++;
      if (rD1 !== 32'h0 || rD2 !== 32'h0) begin
        failures++; $display("FAIL reset_rd a=%0d rD1=%h rD2=%h want 0", a, rD1, rD2);
      end
    end
    checks++;
    if (retire_cnt !== 32'h0) begin
      failures++; $display("FAIL reset_cnt got %h want 0", retire_cnt);
    end
    checks++;
    if ({dbg_wb_have_inst, dbg_wb_pc, dbg_wb_ena, dbg_wb_reg, dbg_wb_value} !== 71'h0) begin
      failures++; $display("FAIL reset_dbg have=%b pc=%h ena=%b reg=%0d val=%h want all 0",
                           dbg_wb_have_inst, dbg_wb_pc, dbg_wb_ena, dbg_wb_reg, dbg_wb_value);
    end
    rst = 1'b0; exp_cnt = 0;
  endtask

  task automatic test_mux;
    logic [31:0] want [4] = '{32'h1234_5678, 32'hAAAA_0001, 32'h0000_1004, 32'hABCD_E000};
    wb_rdo = 32'hAAAA_0001; wb_pc4 = 32'h0000_1004; wb_ext = 32'hABCD_E000;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2'(i), 5'(5 + i), 32'h1234_5678); wb_pc = 32'h1000 + 32'(4 * i); #1;
      checks++;
      if (wb_wD !== want[i]) begin
        failures++; $display("FAIL mux_wD sel=%0d got %h want %h", i, wb_wD, want[i]);
      end
      tick; idle; exp_cnt++;
      rR1 = 5'(5 + i); #1;
      checks++;
      if (rD1 !== want[i]) begin
        failures++; $display("FAIL mux_rd x%0d got %h want %h", 5 + i, rD1, want[i]);
      end
      checks++;
      if (dbg_wb_ena !== 1'b1 || dbg_wb_have_inst !== 1'b1 || dbg_wb_reg !== 5'(5 + i)
          || dbg_wb_value !== want[i] || dbg_wb_pc !== 32'h1000 + 32'(4 * i)) begin
        failures++; $display("FAIL mux_dbg ena=%b have=%b reg=%0d val=%h pc=%h want 1 1 %0d %h %h",
                             dbg_wb_ena, dbg_wb_have_inst, dbg_wb_reg, dbg_wb_value, dbg_wb_pc,
                             5 + i, want[i], 32'h1000 + 32'(4 * i));
      end
    end
    checks++;
    if (retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL mux_cnt got %0d want %0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_x0;
    drive(1, 1, 2'b00, 5'd0, 32'hDEAD_BEEF); tick; idle; exp_cnt++;
    rR1 = 5'd0; #1;
    checks++;
    if (rD1 !== 32'h0) begin
      failures++; $display("FAIL x0_rd got %h want 0", rD1);
    end
    checks++;
    if (dbg_wb_ena !== 1'b0 || dbg_wb_have_inst !== 1'b1) begin
      failures++; $display("FAIL x0_dbg ena=%b have=%b want 0 1", dbg_wb_ena, dbg_wb_have_inst);
    end
    checks++;
    if (retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL x0_cnt got %0d want %0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_bubble;
    drive(1, 1, 2'b00, 5'd9, 32'h0000_0099); tick; exp_cnt++;
    drive(0, 1, 2'b00, 5'd9, 32'hFFFF_FFFF); tick; idle;
    rR1 = 5'd9; #1;
    checks++;
    if (rD1 !== 32'h0000_0099) begin
      failures++; $display("FAIL bubble_rd got %h want 00000099", rD1);
    end
    checks++;
    if (retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL bubble_cnt got %0d want %0d", retire_cnt, exp_cnt);
    end
    checks++;
    if (dbg_wb_have_inst !== 1'b0 || dbg_wb_ena !== 1'b0) begin
      failures++; $display("FAIL bubble_dbg have=%b ena=%b want 0 0", dbg_wb_have_inst, dbg_wb_ena);
    end
  endtask

  task automatic test_same_cycle;
    drive(1, 1, 2'b00, 5'd3, 32'd1); tick; exp_cnt++;
    drive(1, 1, 2'b00, 5'd3, 32'd2); rR2 = 5'd3; #1;
    checks++;
`ifdef RF_WB_BYPASS_EN
    if (rD2 !== 32'd2) begin
      failures++; $display("FAIL same_cycle_rd got %h want 2", rD2);
    end
`else
    if (rD2 !== 32'd1) begin
      failures++; $display("FAIL same_cycle_rd got %h want 1", rD2);
    end
`endif
    tick; idle; exp_cnt++; #1;
    checks++;
    if (rD2 !== 32'd2) begin
      failures++; $display("FAIL next_cycle_rd got %h want 2", rD2);
    end
  endtask

  task automatic test_wrap;
    idle;
    @(negedge clk);
    force dut.retire_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retire_cnt;
    #1;
    checks++;
    if (retire_cnt !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_preload got %h want ffffffff", retire_cnt);
    end
    drive(1, 0, 2'b00, 5'd0, 32'h0); tick; idle;
    checks++;
    if (retire_cnt !== 32'h0) begin
      failures++; $display("FAIL wrap_cnt got %h want 0", retire_cnt);
    end
  endtask

  task automatic test_reset_priority;
    drive(1, 1, 2'b00, 5'd4, 32'h4444_4444); rst = 1'b1; tick; rst = 1'b0; idle;
    rR1 = 5'd4; rR2 = 5'd5; #1;
    checks++;
    if (rD1 !== 32'h0 || rD2 !== 32'h0) begin
      failures++; $display("FAIL rst_prio_rd x4=%h x5=%h want 0 0", rD1, rD2);
    end
    checks++;
    if (retire_cnt !== 32'h0 || dbg_wb_have_inst !== 1'b0) begin
      failures++; $display("FAIL rst_prio_state cnt=%h have=%b want 0 0", retire_cnt, dbg_wb_have_inst);
    end
  endtask

  initial begin
    rst = 1'b1; idle; wb_rf_wsel = 2'b00; wb_wR = '0; wb_C = '0;
    wb_rdo = '0; wb_pc4 = '0; wb_ext = '0; wb_pc = '0; rR1 = '0; rR2 = '0;
    tick; tick; rst = 1'b0;
    test_reset;
    test_mux;
    test_x0;
    test_bubble;
    test_same_cycle;
    test_wrap;
    test_reset_priority;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
